// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: IF-stage PC generator and fetch-redirect controller (RV32I, no RVC).
// Drives instruction-memory requests, applies decode-stage redirects, inserts a
// bubble for every wrong-path word and traps on misaligned branch targets.
module fetch_pc_ctrl #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  clk_en,
  input  logic                  rst,
  input  logic                  branch_taken,
  input  logic [DATA_WIDTH-1:0] jump_address,
  input  logic                  id_stall,
  input  logic                  imem_ready,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] pc_if,
  output logic [DATA_WIDTH-1:0] pc_id,
  output logic                  flush_id,
  output logic                  misaligned,
  output logic [DATA_WIDTH-1:0] mis_addr
);

  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

  typedef enum logic [1:0] {
    S_BOOT,
    S_FETCH,
    S_REDIR_PEND,
    S_TRAP
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_pc_if;
  logic [DATA_WIDTH-1:0] r_pc_id;
  logic [DATA_WIDTH-1:0] r_pend_addr;
  logic [DATA_WIDTH-1:0] r_mis_addr;
  logic                  r_flush_id;
  logic                  r_misaligned;

  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] w_pc_if_nxt;
  logic [DATA_WIDTH-1:0] w_pc_id_nxt;
  logic [DATA_WIDTH-1:0] w_pend_addr_nxt;
  logic [DATA_WIDTH-1:0] w_mis_addr_nxt;
  logic                  w_flush_id_nxt;
  logic                  w_misaligned_nxt;
  logic                  w_br_valid;
  logic                  w_aligned;

  // A branch is only trusted when decode holds a real, non-stalled instruction.
  assign w_br_valid = branch_taken & ~id_stall & ~r_flush_id;
  assign w_aligned  = (jump_address[1:0] == 2'b00);

  // State register and all datapath registers; clk_en freezes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_BOOT;
      r_pc_if      <= RESET_PC;
      r_pc_id      <= RESET_PC;
      r_pend_addr  <= '0;
      r_mis_addr   <= '0;
      r_flush_id   <= 1'b1;
      r_misaligned <= 1'b0;
    end else if (clk_en) begin
      r_state      <= w_state_nxt;
      r_pc_if      <= w_pc_if_nxt;
      r_pc_id      <= w_pc_id_nxt;
      r_pend_addr  <= w_pend_addr_nxt;
      r_mis_addr   <= w_mis_addr_nxt;
      r_flush_id   <= w_flush_id_nxt;
      r_misaligned <= w_misaligned_nxt;
    end
  end

  // Next-state and next-register values; everything holds unless a case says otherwise.
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_if_nxt      = r_pc_if;
    w_pc_id_nxt      = r_pc_id;
    w_pend_addr_nxt  = r_pend_addr;
    w_mis_addr_nxt   = r_mis_addr;
    w_flush_id_nxt   = r_flush_id;
    w_misaligned_nxt = 1'b0;
    unique case (r_state)
      S_BOOT: begin
        w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (w_br_valid) begin
          // The word fetched alongside the branch is wrong-path: always bubble.
          w_flush_id_nxt = 1'b1;
          if (!w_aligned) begin
            w_misaligned_nxt = 1'b1;
            w_mis_addr_nxt   = jump_address;
            w_state_nxt      = S_TRAP;
          end else if (imem_ready) begin
            w_pc_if_nxt = jump_address;
          end else begin
            // Memory is mid-request: keep the address stable and redirect later.
            w_pend_addr_nxt = jump_address;
            w_state_nxt     = S_REDIR_PEND;
          end
        end else if (!id_stall) begin
          if (imem_ready) begin
            w_pc_id_nxt    = r_pc_if;
            w_pc_if_nxt    = r_pc_if + PC_STEP;
            w_flush_id_nxt = 1'b0;
          end else begin
            w_flush_id_nxt = 1'b1;
          end
        end
      end
      S_REDIR_PEND: begin
        // Stall does not block the redirect; the returned word is discarded.
        w_flush_id_nxt = 1'b1;
        if (imem_ready) begin
          w_pc_if_nxt = r_pend_addr;
          w_state_nxt = S_FETCH;
        end
      end
      S_TRAP: begin
        w_flush_id_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = S_BOOT;
      end
    endcase
  end

  assign imem_req   = (r_state == S_FETCH) || (r_state == S_REDIR_PEND);
  assign imem_addr  = r_pc_if;
  assign pc_if      = r_pc_if;
  assign pc_id      = r_pc_id;
  assign flush_id   = r_flush_id;
  assign misaligned = r_misaligned;
  assign mis_addr   = r_mis_addr;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed testbench for fetch_pc_ctrl with hand-computed expectations.
module tb_fetch_pc_ctrl;

  localparam int          DW  = 32;
  localparam logic [31:0] RPC = 32'h0000_0100;

  logic          clk;
  logic          clk_en;
  logic          rst;
  logic          branch_taken;
  logic [DW-1:0] jump_address;
  logic          id_stall;
  logic          imem_ready;
  logic          imem_req;
  logic [DW-1:0] imem_addr;
  logic [DW-1:0] pc_if;
  logic [DW-1:0] pc_id;
  logic          flush_id;
  logic          misaligned;
  logic [DW-1:0] mis_addr;

  int n_checks;
  int n_fail;

  fetch_pc_ctrl #(.DATA_WIDTH(DW), .RESET_PC(RPC)) dut (
    .clk          (clk),
    .clk_en       (clk_en),
    .rst          (rst),
    .branch_taken (branch_taken),
    .jump_address (jump_address),
    .id_stall     (id_stall),
    .imem_ready   (imem_ready),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .pc_if        (pc_if),
    .pc_id        (pc_id),
    .flush_id     (flush_id),
    .misaligned   (misaligned),
    .mis_addr     (mis_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Common group of output checks.
  task automatic chk_fetch(input string tag, input logic req, input logic [31:0] addr,
                           input logic [31:0] pid, input logic fl);
    chk({tag, ".req"},   {31'd0, imem_req}, {31'd0, req});
    chk({tag, ".addr"},  imem_addr, addr);
    chk({tag, ".pcif"},  pc_if, addr);
    chk({tag, ".pcid"},  pc_id, pid);
    chk({tag, ".flush"}, {31'd0, flush_id}, {31'd0, fl});
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst          = 1'b1;
    clk_en       = 1'b1;
    branch_taken = 1'b0;
    jump_address = '0;
    id_stall     = 1'b0;
    imem_ready   = 1'b1;
    #12;
    chk_fetch("rst", 1'b0, 32'h100, 32'h100, 1'b1);
    chk("rst.mis",   {31'd0, misaligned}, 32'd0);
    chk("rst.misad", mis_addr, 32'd0);

    // Sequential fetch from RESET_PC
    @(posedge clk); #1; rst = 1'b0;
    chk_fetch("boot", 1'b0, 32'h100, 32'h100, 1'b1);
    tick(); chk_fetch("f0", 1'b1, 32'h100, 32'h100, 1'b1);
    tick(); chk_fetch("f1", 1'b1, 32'h104, 32'h100, 1'b0);
    tick(); chk_fetch("f2", 1'b1, 32'h108, 32'h104, 1'b0);

    // Taken branch with ready memory: one bubble
    branch_taken = 1'b1; jump_address = 32'h200;
    tick(); chk_fetch("br0", 1'b1, 32'h200, 32'h104, 1'b1);
    branch_taken = 1'b0;
    tick(); chk_fetch("br1", 1'b1, 32'h204, 32'h200, 1'b0);

    // Move back to 0x108 so the pending-redirect case sits at 0x10C
    branch_taken = 1'b1; jump_address = 32'h108;
    tick(); chk_fetch("bk0", 1'b1, 32'h108, 32'h200, 1'b1);
    branch_taken = 1'b0;
    tick(); chk_fetch("bk1", 1'b1, 32'h10C, 32'h108, 1'b0);

    // Branch while memory is busy: redirect deferred, address stable
    imem_ready = 1'b0; branch_taken = 1'b1; jump_address = 32'h300;
    tick(); chk_fetch("rp0", 1'b1, 32'h10C, 32'h108, 1'b1);
    branch_taken = 1'b1; jump_address = 32'h700;
    tick(); chk_fetch("rp1", 1'b1, 32'h10C, 32'h108, 1'b1);
    branch_taken = 1'b0; id_stall = 1'b1;
    tick(); chk_fetch("rp2", 1'b1, 32'h10C, 32'h108, 1'b1);
    imem_ready = 1'b1;
    tick(); chk_fetch("rp3", 1'b1, 32'h300, 32'h108, 1'b1);
    id_stall = 1'b0;
    tick(); chk_fetch("rp4", 1'b1, 32'h304, 32'h300, 1'b0);

    // Stalled decode: branch ignored, PCs hold
    id_stall = 1'b1; branch_taken = 1'b1; jump_address = 32'h400;
    tick(); chk_fetch("st0", 1'b1, 32'h304, 32'h300, 1'b0);
    tick(); chk_fetch("st1", 1'b1, 32'h304, 32'h300, 1'b0);
    id_stall = 1'b0; branch_taken = 1'b0;

    // clk_en low freezes everything
    clk_en = 1'b0;
    tick(); chk_fetch("ce0", 1'b1, 32'h304, 32'h300, 1'b0);
    tick(); chk_fetch("ce1", 1'b1, 32'h304, 32'h300, 1'b0);
    clk_en = 1'b1;
    tick(); chk_fetch("ce2", 1'b1, 32'h308, 32'h304, 1'b0);

    // PC wrap at the top of the address space
    branch_taken = 1'b1; jump_address = 32'hFFFF_FFFC;
    tick(); chk_fetch("wr0", 1'b1, 32'hFFFF_FFFC, 32'h304, 1'b1);
    branch_taken = 1'b0;
    tick(); chk_fetch("wr1", 1'b1, 32'h0, 32'hFFFF_FFFC, 1'b0);

    // Memory not ready without branch: bubble, PC held
    imem_ready = 1'b0;
    tick(); chk_fetch("nr0", 1'b1, 32'h0, 32'hFFFF_FFFC, 1'b1);
    imem_ready = 1'b1;
    tick(); chk_fetch("nr1", 1'b1, 32'h4, 32'h0, 1'b0);

    // Misaligned target traps
    branch_taken = 1'b1; jump_address = 32'h202;
    tick(); chk_fetch("tr0", 1'b0, 32'h4, 32'h0, 1'b1);
    chk("tr0.mis",   {31'd0, misaligned}, 32'd1);
    chk("tr0.misad", mis_addr, 32'h202);
    jump_address = 32'h500;
    tick(); chk_fetch("tr1", 1'b0, 32'h4, 32'h0, 1'b1);
    chk("tr1.mis",   {31'd0, misaligned}, 32'd0);
    chk("tr1.misad", mis_addr, 32'h202);
    branch_taken = 1'b0;

    // Reset out of trap
    #2; rst = 1'b1; #1;
    chk_fetch("trst", 1'b0, 32'h100, 32'h100, 1'b1);
    chk("trst.misad", mis_addr, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    tick(); chk_fetch("tx0", 1'b1, 32'h100, 32'h100, 1'b1);
    tick(); chk_fetch("tx1", 1'b1, 32'h104, 32'h100, 1'b0);

    // Async reset in the middle of a pending redirect
    imem_ready = 1'b0; branch_taken = 1'b1; jump_address = 32'h500;
    tick(); chk_fetch("pr0", 1'b1, 32'h104, 32'h100, 1'b1);
    branch_taken = 1'b0;
    #2; rst = 1'b1; #1;
    chk_fetch("prst", 1'b0, 32'h100, 32'h100, 1'b1);
    @(posedge clk); #1; rst = 1'b0; imem_ready = 1'b1;
    tick(); chk_fetch("px0", 1'b1, 32'h100, 32'h100, 1'b1);
    tick(); chk_fetch("px1", 1'b1, 32'h104, 32'h100, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
- PC generator and fetch-redirect controller for the IF stage.
- Consumes the decode-stage branch resolution (branch_taken, jump_address) and steers instruction-memory fetch.
- Kills the wrong-path instruction and supplies the PC of each decoded instruction back to decode and branch logic.
- Traps on misaligned targets; RV32I only, no compressed instructions.

Parameters:
- DATA_WIDTH, 32, width of PC and address buses.
- RESET_PC, 32'h0000_0000, first fetch address after reset; must be 4-byte aligned.

Ports:
- clk  input  1  clock.
- clk_en  input  1  clock enable; when 0, every register holds.
- rst  input  1  asynchronous reset, active-high.
- branch_taken  input  1  decode stage resolved a taken branch or jump.
- jump_address  input  DATA_WIDTH  target for branch_taken.
- id_stall  input  1  hazard stall; IF/ID must hold.
- imem_ready  input  1  memory accepts the request and returns data this cycle.
- imem_req  output  1  fetch request.
- imem_addr  output  DATA_WIDTH  fetch address; equals pc_if.
- pc_if  output  DATA_WIDTH  PC currently being fetched.
- pc_id  output  DATA_WIDTH  PC of the instruction in IF/ID.
- flush_id  output  1  IF/ID holds a bubble; decode must treat it as a NOP.
- misaligned  output  1  one-cycle pulse on a misaligned taken target.
- mis_addr  output  DATA_WIDTH  offending target, latched.

Behaviour:
- Reset (async, any time, including mid-transaction):
  - state=BOOT, pc_if=RESET_PC, pc_id=RESET_PC, imem_req=0, flush_id=1, misaligned=0, mis_addr=0.
  - Any pending redirect is discarded.
- General rules:
  - All transitions occur only on clk rising edges with clk_en=1.
  - A fetch completes in a cycle where imem_req=1 and imem_ready=1.
  - imem_addr must stay stable while imem_req=1 and imem_ready=0.
  - branch_taken is qualified: it is ignored when id_stall=1 or flush_id=1 (operands invalid or bubble).
- State BOOT: imem_req=0. On the next edge go to FETCH.
- State FETCH: imem_req=1.
  - Valid branch_taken, jump_address[1:0]==0, imem_ready=1: pc_if<=jump_address, flush_id<=1 (wrong-path word dropped), stay FETCH. One bubble per taken branch.
  - Valid branch_taken, aligned target, imem_ready=0: latch target into pend_addr, go to REDIR_PEND. pc_if and imem_addr are unchanged.
  - Valid branch_taken, jump_address[1:0]!=0: misaligned<=1 for one cycle, mis_addr<=jump_address, flush_id<=1, go to TRAP.
  - No branch, imem_ready=1, id_stall=0: pc_id<=pc_if, pc_if<=pc_if+4 (modulo 2^DATA_WIDTH; 32'hFFFF_FFFC wraps to 0), flush_id<=0.
  - No branch, imem_ready=1, id_stall=1: pc_if and pc_id hold; flush_id holds; the returned word is re-fetched later.
  - No branch, imem_ready=0, id_stall=0: flush_id<=1 (bubble); pc held.
  - No branch, imem_ready=0, id_stall=1: all hold.
- State REDIR_PEND: imem_req=1, imem_addr=old pc_if, flush_id=1, branch_taken ignored.
  - On imem_ready=1: pc_if<=pend_addr, go to FETCH. The returned word is discarded.
- State TRAP: imem_req=0, flush_id=1, pc_if and pc_id held. Exit only via rst.
- id_stall never blocks a redirect already latched in REDIR_PEND.
- Latency:
  - Redirect to first target request: 1 cycle.
  - Target instruction in IF/ID: 2 cycles after the branch is resolved in decode, with ready memory.

Test Plan:
- Reset with RESET_PC=0x100, imem_ready=1 tied high: imem_addr sequence 0x100, 0x104, 0x108; pc_id lags by 1 cycle; flush_id=0 from the second fetch on.
- At pc_if=0x108, pulse branch_taken with jump_address=0x200: next imem_addr=0x200; flush_id=1 for exactly 1 cycle; pc_id=0x200 one cycle later.
- imem_ready=0 for 3 cycles at addr 0x10C while branch_taken arrives with target 0x300: imem_addr stays 0x10C until ready; next address is 0x300; the word at 0x10C never reaches IF/ID (flush_id=1).
- Target 0x202 taken: misaligned=1 for 1 cycle, mis_addr=0x202, imem_req=0 thereafter; rst returns fetch to RESET_PC.
- Hold id_stall=1 for 2 cycles with branch_taken=1: no redirect, pc_if/pc_id constant; clk_en=0 freezes all outputs; pc_if=0xFFFF_FFFC increments to 0x0.
- Assert rst in the middle of REDIR_PEND: outputs asynchronously take reset values; pend_addr is discarded; first fetch after release is RESET_PC.
